// File: rtl/z80_io_pkg.sv
// Shared types and widths for the Z80 I/O cycle front end.
package z80_io_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACTIVE,
        HOLD,
        RELEASE
    } ioState_e;

endpackage

// File: rtl/z80_io_cycle_ctl_sync2.sv
// io_sync2: two-flop synchroniser for one asynchronous, active-low Z80 control line.
// Resets to 1 so an idle bus is seen while the flops are held in reset.
module io_sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    // Two back-to-back flops give the first stage a full clock to settle.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments make both flops sample the old values
        // at the same edge; blocking ones would collapse the chain to one stage.
        if (!reset_n) begin
            meta    <= 1'b1;
            syncOut <= 1'b1;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/z80_io_cycle_ctl.sv
// z80_io_cycle_ctl: qualifies Z80 I/O cycles into clean clock-domain strobes,
// latches port address and write data, and stretches _WAIT for a programmable
// minimum plus any peripheral busy time.
// Optional feature: define IO_TIMEOUT_EN to add a busy watchdog that forces
// _WAIT high after TIMEOUT_CYCLES busy clocks and sets the sticky io_timeout.
module z80_io_cycle_ctl
    import z80_io_pkg::*;
#(
    parameter int WAIT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_iorq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic              cpu_m1_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              periph_busy,
    output logic [ADDR_W-1:0] address,
    output logic              ioread,
    output logic              iowrite,
    output logic              io_rd_pulse,
    output logic              io_wr_pulse,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_wait_n,
    output logic              io_timeout
);

    localparam int               CNT_W     = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    // Reject configurations the counters cannot represent.
    if (WAIT_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : gBadParams
        $error("z80_io_cycle_ctl: WAIT_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic syncIorq, syncRd, syncWr, syncM1;
    logic prevRd, prevWr, prevM1;
    ioState_e state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext, waitCntDec;
    logic waitNNext, ioreadNext, iowriteNext, rdPulseNext, wrPulseNext, latchEn, stable;

    io_sync2 uIorqSync (.clock(clock), .reset_n(reset_n), .asyncIn(cpu_iorq_n), .syncOut(syncIorq));
    io_sync2 uRdSync   (.clock(clock), .reset_n(reset_n), .asyncIn(cpu_rd_n),   .syncOut(syncRd));
    io_sync2 uWrSync   (.clock(clock), .reset_n(reset_n), .asyncIn(cpu_wr_n),   .syncOut(syncWr));
    io_sync2 uM1Sync   (.clock(clock), .reset_n(reset_n), .asyncIn(cpu_m1_n),   .syncOut(syncM1));

`ifdef IO_TIMEOUT_EN
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wdog, wdogNext;
    logic       timeoutNext;
`endif

    // The control lines must read the same on two consecutive clocks before a cycle qualifies.
    assign stable     = (syncRd == prevRd) && (syncWr == prevWr) && (syncM1 == prevM1);
    assign waitCntDec = (waitCnt == '0) ? '0 : waitCnt - 1'b1;

    // Next-state and next-output decode for the I/O cycle FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned
        // and infers a latch.
        stateNext   = state;
        waitNNext   = cpu_wait_n;
        ioreadNext  = ioread;
        iowriteNext = iowrite;
        rdPulseNext = 1'b0;
        wrPulseNext = 1'b0;
        waitCntNext = waitCnt;
        latchEn     = 1'b0;
`ifdef IO_TIMEOUT_EN
        wdogNext    = wdog;
        timeoutNext = io_timeout;
`endif
        case (state)
            IDLE: begin
                if (!syncIorq) begin
                    stateNext = SETTLE;
                    waitNNext = 1'b0;
                end
            end
            SETTLE: begin
                if (syncIorq) begin
                    stateNext = IDLE;
                    waitNNext = 1'b1;
                end else if (stable) begin
                    if (!syncM1 || (!syncRd && !syncWr)) begin
                        // Interrupt acknowledge or an illegal rd+wr cycle: no strobes.
                        stateNext = RELEASE;
                        waitNNext = 1'b1;
                    end else if (syncRd != syncWr) begin
                        stateNext   = ACTIVE;
                        latchEn     = 1'b1;
                        ioreadNext  = !syncRd;
                        iowriteNext = !syncWr;
                        rdPulseNext = !syncRd;
                        wrPulseNext = !syncWr;
                        waitCntNext = WAIT_LOAD;
`ifdef IO_TIMEOUT_EN
                        wdogNext    = '0;
`endif
                    end
                end
            end
            ACTIVE: begin
                waitCntNext = waitCntDec;
                if (waitCntDec == '0) begin
                    if (!periph_busy) begin
                        stateNext = HOLD;
                        waitNNext = 1'b1;
                    end
`ifdef IO_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        stateNext   = HOLD;
                        waitNNext   = 1'b1;
                        timeoutNext = 1'b1;
                    end else begin
                        wdogNext = wdog + 1'b1;
                    end
`endif
                end
            end
            HOLD: begin
                if (syncIorq) begin
                    stateNext   = IDLE;
                    ioreadNext  = 1'b0;
                    iowriteNext = 1'b0;
                end
            end
            RELEASE: begin
                waitNNext = 1'b1;
                if (syncIorq) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: address and wr_data are ordinary flops, not a memory, so they take
        // a defined reset value like every other register here.
        if (!reset_n) begin
            state       <= IDLE;
            cpu_wait_n  <= 1'b1;
            ioread      <= 1'b0;
            iowrite     <= 1'b0;
            io_rd_pulse <= 1'b0;
            io_wr_pulse <= 1'b0;
            waitCnt     <= '0;
            address     <= '0;
            wr_data     <= '0;
            prevRd      <= 1'b1;
            prevWr      <= 1'b1;
            prevM1      <= 1'b1;
        end else begin
            state       <= stateNext;
            cpu_wait_n  <= waitNNext;
            ioread      <= ioreadNext;
            iowrite     <= iowriteNext;
            io_rd_pulse <= rdPulseNext;
            io_wr_pulse <= wrPulseNext;
            waitCnt     <= waitCntNext;
            prevRd      <= syncRd;
            prevWr      <= syncWr;
            prevM1      <= syncM1;
            if (latchEn) begin
                address <= cpu_addr;
                wr_data <= cpu_dout;
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    // Busy watchdog counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog       <= '0;
            io_timeout <= 1'b0;
        end else begin
            wdog       <= wdogNext;
            io_timeout <= timeoutNext;
        end
    end
`else
    assign io_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_z80_io_cycle_ctl.sv
// Self-checking bench for z80_io_cycle_ctl. Expected timing comes from the
// cycle rules: _WAIT low 3 clocks after _IORQ, strobe at 4 clocks, _WAIT low
// for WAIT_CYCLES + busy clocks + 1. Define IO_TIMEOUT_EN to exercise the watchdog.
module tb_z80_io_cycle_ctl;

    localparam int WAIT_CYCLES = 4;
`ifdef IO_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 15;
    localparam bit TIMEOUT_ON     = 1'b1;
`else
    localparam int TIMEOUT_CYCLES = 1023;
    localparam bit TIMEOUT_ON     = 1'b0;
`endif

    localparam int K_OUT  = 0;
    localparam int K_IN   = 1;
    localparam int K_INTA = 2;
    localparam int K_BOTH = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, periph_busy;
    logic [7:0] cpu_addr, cpu_dout, address, wr_data;
    logic       ioread, iowrite, io_rd_pulse, io_wr_pulse, cpu_wait_n, io_timeout;

    int         errors = 0;
    int         checks = 0;

    // Reference state of the latched outputs.
    logic [7:0] expAddr = 8'h00;
    logic [7:0] expData = 8'h00;
    logic       expTimeout = 1'b0;

    z80_io_cycle_ctl #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_m1_n(cpu_m1_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .periph_busy(periph_busy),
        .address(address), .ioread(ioread), .iowrite(iowrite),
        .io_rd_pulse(io_rd_pulse), .io_wr_pulse(io_wr_pulse), .wr_data(wr_data),
        .cpu_wait_n(cpu_wait_n), .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Busy seen by edge k of a cycle: don't-care before count 0, then high for busyClks edges.
    function automatic logic busy_at(input int k, input int busyClks);
        if (k < 4 + WAIT_CYCLES) return logic'($urandom_range(0, 1));
        return (k < 4 + WAIT_CYCLES + busyClks);
    endfunction

    // Run one bus cycle of the given kind and compare it against the cycle rules.
    task automatic do_cycle(input int kind, input logic [7:0] addr, input logic [7:0] data,
                            input int busyClks, input int gap);
        int  firstLow = -1, releaseK = -1, lowCount = 0, pulseK = -1, pulseCount = 0;
        int  wrongPulse = 0, levelBad = 0, clearK = -1, stray = 0;
        int  heldBusy, expRelease;
        bit  strobes;

        strobes  = (kind == K_OUT) || (kind == K_IN);
        heldBusy = (TIMEOUT_ON && busyClks > TIMEOUT_CYCLES - 1) ? TIMEOUT_CYCLES - 1 : busyClks;
        expRelease = strobes ? 4 + WAIT_CYCLES + heldBusy : 4;

        @(negedge clock);
        cpu_addr    = addr;
        cpu_dout    = data;
        cpu_iorq_n  = 1'b0;
        cpu_rd_n    = !(kind == K_IN || kind == K_BOTH);
        cpu_wr_n    = !(kind == K_OUT || kind == K_BOTH);
        cpu_m1_n    = (kind != K_INTA);
        periph_busy = busy_at(1, busyClks);

        for (int k = 1; k <= 4 + WAIT_CYCLES + busyClks + 40; k++) begin
            @(posedge clock);
            #1;
            if (!cpu_wait_n) begin
                lowCount++;
                if (firstLow < 0) firstLow = k;
            end else if (firstLow >= 0) begin
                releaseK = k;
            end
            if (io_rd_pulse || io_wr_pulse) begin
                pulseCount++;
                if (pulseK < 0) pulseK = k;
                if (!strobes || (io_rd_pulse && kind != K_IN) || (io_wr_pulse && kind != K_OUT))
                    wrongPulse++;
            end
            if ((ioread && kind != K_IN) || (iowrite && kind != K_OUT)) levelBad++;
            if (k >= 4 && kind == K_IN && !ioread) levelBad++;
            if (k >= 4 && kind == K_OUT && !iowrite) levelBad++;
            if (releaseK >= 0) break;
            periph_busy = busy_at(k + 1, busyClks);
        end

        check_eq("wait_low_latency", firstLow, 3);
        check_eq("wait_release_clock", releaseK, expRelease);
        check_eq("wait_low_clocks", lowCount, expRelease - 3);
        check_eq("pulse_count", pulseCount, strobes ? 1 : 0);
        if (strobes) check_eq("pulse_latency", pulseK, 4);
        check_eq("wrong_pulse", wrongPulse, 0);
        check_eq("strobe_level", levelBad, 0);

        if (strobes) begin
            expAddr = addr;
            expData = data;
        end
        if (TIMEOUT_ON && strobes && busyClks >= TIMEOUT_CYCLES) expTimeout = 1'b1;
        check_eq("address", int'(address), int'(expAddr));
        check_eq("wr_data", int'(wr_data), int'(expData));
        check_eq("io_timeout", int'(io_timeout), int'(expTimeout));

        // End the bus cycle; strobes must clear once the synchronised _IORQ is high.
        cpu_iorq_n  = 1'b1;
        cpu_rd_n    = 1'b1;
        cpu_wr_n    = 1'b1;
        cpu_m1_n    = 1'b1;
        periph_busy = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clock);
            #1;
            if (io_rd_pulse || io_wr_pulse || !cpu_wait_n) stray++;
            if (clearK < 0 && !ioread && !iowrite) clearK = j;
            if (j >= 2 && clearK >= 0) break;
        end
        check_eq("strobe_cleared", (clearK >= 1 && clearK <= 3) ? 1 : 0, 1);
        check_eq("tail_activity", stray, 0);

        for (int g = 0; g < gap; g++) begin
            @(posedge clock);
            #1;
            if (io_rd_pulse || io_wr_pulse || ioread || iowrite || !cpu_wait_n) stray++;
        end
        if (gap > 0) check_eq("idle_activity", stray, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1; cpu_m1_n = 1'b1;
        cpu_addr = 8'h00; cpu_dout = 8'h00; periph_busy = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_address", int'(address), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        check_eq("rst_strobes", int'({ioread, iowrite, io_rd_pulse, io_wr_pulse}), 0);
        check_eq("rst_wait_n", int'(cpu_wait_n), 1);
        check_eq("rst_timeout", int'(io_timeout), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("idle_after_reset", int'({ioread, iowrite, io_rd_pulse, io_wr_pulse, !cpu_wait_n}), 0);
    endtask

    task automatic test_out();
        do_cycle(K_OUT, 8'h6C, 8'hA5, 0, 2);
    endtask

    task automatic test_in();
        do_cycle(K_IN, 8'h36, 8'h5A, 0, 2);
    endtask

    task automatic test_inta();
        do_cycle(K_INTA, 8'hFF, 8'h11, 0, 2);
        do_cycle(K_BOTH, 8'h12, 8'h34, 0, 2);
    endtask

    task automatic test_busy();
        do_cycle(K_OUT, 8'h80, 8'h3C, 20, 1);
    endtask

    task automatic test_back_to_back();
        do_cycle(K_OUT, 8'h01, 8'hC3, 0, 0);
        do_cycle(K_IN,  8'h02, 8'h00, 1, 0);
        do_cycle(K_OUT, 8'h03, 8'h7E, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int r    = int'($urandom_range(0, 9));
            int kind = (r < 4) ? K_OUT : (r < 8) ? K_IN : (r == 8) ? K_INTA : K_BOTH;
            do_cycle(kind, 8'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_timeout();
        // Busy stuck high: the watchdog (when built in) ends the stretch, otherwise busy drops late.
        do_cycle(K_OUT, 8'h44, 8'h99, TIMEOUT_ON ? 60 : 30, 1);
        do_cycle(K_IN, 8'h45, 8'h00, 0, 1);
    endtask

    task automatic test_reset_mid_cycle();
        @(negedge clock);
        cpu_addr = 8'hE7; cpu_dout = 8'h18; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0; periph_busy = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check_eq("mid_cycle_active", int'({iowrite, cpu_wait_n}), 2);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_wait_n", int'(cpu_wait_n), 1);
        check_eq("mid_rst_strobes", int'({ioread, iowrite, io_rd_pulse, io_wr_pulse}), 0);
        check_eq("mid_rst_address", int'(address), 0);
        check_eq("mid_rst_timeout", int'(io_timeout), 0);
        expAddr = 8'h00; expData = 8'h00; expTimeout = 1'b0;
        cpu_iorq_n = 1'b1; cpu_wr_n = 1'b1; periph_busy = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        begin
            int stray = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clock);
                #1;
                if (io_rd_pulse || io_wr_pulse || ioread || iowrite || !cpu_wait_n) stray++;
            end
            check_eq("post_reset_idle", stray, 0);
        end
        do_cycle(K_IN, 8'h5D, 8'h00, 0, 1);
    endtask

    initial begin
        test_reset();
        test_out();
        test_in();
        test_inta();
        test_busy();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
